// File: rtl/fetch_queue.sv
// Fetch front end: drives the icache lookup, selects the 32-bit instruction and queues {inst, pc} for decode.
// Hits appear at the queue head one cycle later; lookups stop while the queue is full or a fill is outstanding.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     Icache_valid_out,
  input  logic [63:0]              Icache_data_out,
  output logic [XLEN-1:0]          proc2Icache_addr,
  output logic                     read_valid,
  input  logic                     branch_taken,
  input  logic [XLEN-1:0]          branch_target,
  input  logic                     id_ready,
  output logic                     if_valid,
  output logic [31:0]              if_inst,
  output logic [XLEN-1:0]          if_pc,
  output logic [XLEN-1:0]          if_npc,
  output logic [$clog2(DEPTH):0]   fq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef enum logic {FETCH, WAIT_FILL} state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] redirect_pc;
  logic            pending_redirect;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  logic            full;
  logic            push;
  logic            pop;
  logic [31:0]     hit_inst;
  logic [XLEN-1:0] target;

  assign full     = (count == CW'(DEPTH));
  // Gated by reset_n so the lookup request drops the instant reset asserts.
  assign read_valid = reset_n && (state == FETCH) && !full && !branch_taken;
  assign push     = read_valid && Icache_valid_out;
  assign pop      = if_valid && id_ready && !branch_taken;
  assign target   = branch_target & ~XLEN'(3);
  assign hit_inst = fetch_pc[2] ? Icache_data_out[63:32] : Icache_data_out[31:0];

  assign proc2Icache_addr = fetch_pc;
  assign fq_count = count;
  assign if_valid = (count != '0);
  assign if_inst  = mem[head].inst;
  assign if_pc    = mem[head].pc;
  assign if_npc   = mem[head].pc + XLEN'(4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= FETCH;
      fetch_pc         <= RESET_PC;
      redirect_pc      <= RESET_PC;
      pending_redirect <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (branch_taken) begin
            fetch_pc <= target;
          end else if (read_valid) begin
            if (Icache_valid_out) fetch_pc <= fetch_pc + XLEN'(4);
            else                  state    <= WAIT_FILL;
          end
        end
        WAIT_FILL: begin
          // The lookup address must stay put until the fill lands; redirects are deferred.
          if (Icache_valid_out) begin
            state            <= FETCH;
            pending_redirect <= 1'b0;
            if (branch_taken)          fetch_pc <= target;
            else if (pending_redirect) fetch_pc <= redirect_pc;
          end else if (branch_taken) begin
            redirect_pc      <= target;
            pending_redirect <= 1'b1;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (branch_taken) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{inst: hit_inst, pc: fetch_pc};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: per-cycle vector table plus scoreboarded fetch sequences with an icache miss model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Icache_valid_out;
  logic [63:0] Icache_data_out;
  logic [31:0] proc2Icache_addr;
  logic        read_valid;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_npc;
  logic [3:0]  fq_count;

  int tests = 0;
  int fails = 0;

  logic        miss_active;
  logic [31:0] miss_line;
  int          fill_cnt;
  logic        last_fill;
  logic        sb_on;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .Icache_valid_out(Icache_valid_out), .Icache_data_out(Icache_data_out),
    .proc2Icache_addr(proc2Icache_addr), .read_valid(read_valid),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .id_ready(id_ready), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .if_npc(if_npc), .fq_count(fq_count)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A3C_0F00;
  endfunction

  // Icache model: every line hits except the one line marked as missing until its fill completes.
  assign Icache_data_out  = {inst_of({proc2Icache_addr[31:3], 3'b100}), inst_of({proc2Icache_addr[31:3], 3'b000})};
  assign Icache_valid_out = !(miss_active && (proc2Icache_addr[31:3] == miss_line[31:3]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic br, input logic [31:0] tgt);
    logic [31:0] e;
    @(negedge clk);
    if (last_fill) begin
      fill_cnt--;
      if (fill_cnt == 0) miss_active = 1'b0;
    end
    id_ready = rdy; branch_taken = br; branch_target = tgt;
    #1;
    last_fill = miss_active && !read_valid && (proc2Icache_addr[31:3] == miss_line[31:3]);
    if (sb_on && if_valid && id_ready && !branch_taken) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_pop", 64'(if_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", 64'(if_pc), 64'(e));
        chk("sb_inst", 64'(if_inst), 64'(inst_of(e)));
        chk("sb_npc", 64'(if_npc), 64'(e + 32'd4));
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; id_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    miss_active = 1'b0; miss_line = '0; fill_cnt = 0; last_fill = 1'b0;
    sb_on = 1'b0; exp_q.delete();
    @(posedge clk); #2;
    chk("rst_read_valid", 64'(read_valid), 64'd0);
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_addr", 64'(proc2Icache_addr), 64'd0);
    chk("rst_count", 64'(fq_count), 64'd0);
    reset_n = 1'b1;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) step(1'b1, 1'b0, 32'h0);
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic        rdy;
    int          cnt;
    logic        rv;
    logic [31:0] addr;
    logic        ifv;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic rdy, input int cnt, input logic rv,
                              input logic [31:0] addr, input logic ifv, input logic [31:0] pc);
    vec_t v;
    v.rdy = rdy; v.cnt = cnt; v.rv = rv; v.addr = addr; v.ifv = ifv; v.pc = pc;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    id_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    miss_active = 1'b0; miss_line = '0; fill_cnt = 0; last_fill = 1'b0; sb_on = 1'b0;

    // Fill to full with decode stalled, then single pops and a push+pop at full-minus-one.
    tbl[0]  = mk(0, 0, 1, 32'h00, 0, 32'h0);
    tbl[1]  = mk(0, 1, 1, 32'h04, 1, 32'h0);
    tbl[2]  = mk(0, 2, 1, 32'h08, 1, 32'h0);
    tbl[3]  = mk(0, 3, 1, 32'h0C, 1, 32'h0);
    tbl[4]  = mk(0, 4, 1, 32'h10, 1, 32'h0);
    tbl[5]  = mk(0, 5, 1, 32'h14, 1, 32'h0);
    tbl[6]  = mk(0, 6, 1, 32'h18, 1, 32'h0);
    tbl[7]  = mk(0, 7, 1, 32'h1C, 1, 32'h0);
    tbl[8]  = mk(0, 8, 0, 32'h20, 1, 32'h0);
    tbl[9]  = mk(0, 8, 0, 32'h20, 1, 32'h0);
    tbl[10] = mk(1, 8, 0, 32'h20, 1, 32'h0);
    tbl[11] = mk(0, 7, 1, 32'h20, 1, 32'h4);
    tbl[12] = mk(0, 8, 0, 32'h24, 1, 32'h4);
    tbl[13] = mk(1, 8, 0, 32'h24, 1, 32'h4);
    tbl[14] = mk(1, 7, 1, 32'h24, 1, 32'h8);
    tbl[15] = mk(1, 7, 1, 32'h28, 1, 32'hC);
    tbl[16] = mk(0, 7, 1, 32'h2C, 1, 32'h10);
    tbl[17] = mk(0, 8, 0, 32'h30, 1, 32'h10);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rdy, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_count", i), 64'(fq_count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_read_valid", i), 64'(read_valid), 64'(tbl[i].rv));
      chk($sformatf("tbl%0d_addr", i), 64'(proc2Icache_addr), 64'(tbl[i].addr));
      chk($sformatf("tbl%0d_if_valid", i), 64'(if_valid), 64'(tbl[i].ifv));
      if (tbl[i].ifv) begin
        chk($sformatf("tbl%0d_if_pc", i), 64'(if_pc), 64'(tbl[i].pc));
        chk($sformatf("tbl%0d_if_inst", i), 64'(if_inst), 64'(inst_of(tbl[i].pc)));
      end
    end

    // Streaming all-hit: one instruction per cycle, head valid from the second cycle.
    do_reset();
    sb_on = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
    step(1'b1, 1'b0, 32'h0);
    chk("t1_first_cycle_empty", 64'(if_valid), 64'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("t1_second_cycle_valid", 64'(if_valid), 64'd1);
    drain("t1_drain");

    // Miss at 0x40 with a 10-cycle fill.
    do_reset();
    miss_active = 1'b1; miss_line = 32'h40; fill_cnt = 10;
    sb_on = 1'b1;
    for (int i = 0; i < 18; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (proc2Icache_addr == 32'h40 && read_valid && !Icache_valid_out) break;
    end
    chk("t3_miss_seen", 64'(proc2Icache_addr), 64'h40);
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk($sformatf("t3_wait%0d_read_valid", i), 64'(read_valid), 64'd0);
      chk($sformatf("t3_wait%0d_addr", i), 64'(proc2Icache_addr), 64'h40);
      chk($sformatf("t3_wait%0d_fill", i), 64'(Icache_valid_out), 64'(i == 10));
    end
    step(1'b1, 1'b0, 32'h0);
    chk("t3_refetch_read_valid", 64'(read_valid), 64'd1);
    chk("t3_refetch_addr", 64'(proc2Icache_addr), 64'h40);
    drain("t3_drain");

    // Redirect in FETCH while a push and a pop are both happening.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h103);
    chk("t4_branch_if_valid", 64'(if_valid), 64'd1);
    chk("t4_branch_read_valid", 64'(read_valid), 64'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("t4_flush_count", 64'(fq_count), 64'd0);
    chk("t4_flush_if_valid", 64'(if_valid), 64'd0);
    chk("t4_target_addr", 64'(proc2Icache_addr), 64'h100);
    step(1'b1, 1'b0, 32'h0);
    chk("t4_first_if_pc", 64'(if_pc), 64'h100);

    // Redirect while waiting for a fill at 0x80: address held, old PC never delivered.
    do_reset();
    miss_active = 1'b1; miss_line = 32'h80; fill_cnt = 6;
    sb_on = 1'b1;
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(i * 4));
    exp_q.push_back(32'h200); exp_q.push_back(32'h204); exp_q.push_back(32'h208);
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (proc2Icache_addr == 32'h80 && !read_valid) break;
    end
    chk("t5_wait_seen", 64'(read_valid), 64'd0);
    step(1'b1, 1'b1, 32'h200);
    chk("t5_branch_addr", 64'(proc2Icache_addr), 64'h80);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk($sformatf("t5_hold%0d_addr", i), 64'(proc2Icache_addr), 64'h80);
      if (Icache_valid_out) break;
    end
    step(1'b1, 1'b0, 32'h0);
    chk("t5_redirect_addr", 64'(proc2Icache_addr), 64'h200);
    chk("t5_redirect_read_valid", 64'(read_valid), 64'd1);
    drain("t5_drain");

    // Asynchronous reset in the middle of a fill wait.
    do_reset();
    miss_active = 1'b1; miss_line = 32'h10; fill_cnt = 100;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (proc2Icache_addr == 32'h10 && !read_valid) break;
    end
    chk("t6_pre_count", 64'(fq_count), 64'd4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_read_valid", 64'(read_valid), 64'd0);
    chk("t6_async_if_valid", 64'(if_valid), 64'd0);
    chk("t6_async_addr", 64'(proc2Icache_addr), 64'd0);
    chk("t6_async_count", 64'(fq_count), 64'd0);
    miss_active = 1'b0; last_fill = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    chk("t6_resume_read_valid", 64'(read_valid), 64'd1);
    chk("t6_resume_addr", 64'(proc2Icache_addr), 64'd0);
    step(1'b0, 1'b0, 32'h0);
    chk("t6_next_addr", 64'(proc2Icache_addr), 64'h4);
    chk("t6_head_pc", 64'(if_pc), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
